// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder:
// funct3 codes, FSM state encoding, latched request layout, legality check.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } mem_req_t;

    // Misaligned half/word, unsigned store variants and unused funct3 codes are all errors.
    function automatic logic access_err(input logic write, input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = write;
            F3_HU:   err = write | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // lane select followed by extension
    always_comb begin
        byte_s = 8'(word >> {byte_off, 3'b000});
        if (byte_off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_W:    data = word;
            F3_BU:   data = {24'd0, byte_s};
            F3_HU:   data = {16'd0, half_s};
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: accepts one load/store, stalls the pipeline for
// LATENCY cycles, then pulses a registered response; stores commit as RESP ends.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    mem_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    mem_req_t         req_r;
    logic [31:0]      mem_r [DEPTH_WORDS];

    mem_req_t    in_s;
    mem_req_t    src_s;
    logic        src_err_s;
    logic [31:0] rd_word_s;
    logic [31:0] ext_s;
    logic [31:0] rsp_data_s;
    logic [4:0]  rsp_rd_s;
    logic        wr_en_s;
    logic [3:0]  wr_mask_s;
    logic [31:0] wr_data_s;
    logic        unused_s;

    assign in_s  = '{write: req_write, funct3: req_funct3, addr: req_addr,
                     wdata: req_wdata, rd: req_rd};
    assign stall = rst_n & (((state_r == IDLE) & req_valid) | (state_r == WAIT));
    assign unused_s = ^{src_s.addr[31:AW+2], req_r.addr[31:AW+2]};

    // With LATENCY=1 the response is formed from the live request, otherwise from the latched one.
    always_comb begin
        if (state_r == IDLE) begin
            src_s = in_s;
        end else begin
            src_s = req_r;
        end
        rd_word_s = mem_r[src_s.addr[AW+1:2]];
        src_err_s = access_err(src_s.write, src_s.funct3, src_s.addr[1:0]);
        if (src_err_s || src_s.write) begin
            rsp_data_s = 32'd0;
            rsp_rd_s   = 5'd0;
        end else begin
            rsp_data_s = ext_s;
            rsp_rd_s   = src_s.rd;
        end
    end

    load_extend u_load_extend (
        .word     (rd_word_s),
        .byte_off (src_s.addr[1:0]),
        .funct3   (src_s.funct3),
        .data     (ext_s)
    );

    // store byte mask and lane-replicated data for the latched request
    always_comb begin
        wr_en_s = rst_n & (state_r == RESP) & req_r.write
                  & ~access_err(req_r.write, req_r.funct3, req_r.addr[1:0]);
        case (req_r.funct3)
            F3_B: begin
                wr_mask_s = 4'b0001 << req_r.addr[1:0];
                wr_data_s = {4{req_r.wdata[7:0]}};
            end
            F3_H: begin
                wr_mask_s = req_r.addr[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{req_r.wdata[15:0]}};
            end
            F3_W: begin
                wr_mask_s = 4'b1111;
                wr_data_s = req_r.wdata;
            end
            default: begin
                wr_mask_s = 4'b0000;
                wr_data_s = 32'd0;
            end
        endcase
    end

    // array write port; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask_s[i]) begin
                    mem_r[req_r.addr[AW+1:2]][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // request FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            req_r      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_rd    <= 5'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_rd    <= 5'd0;
            resp_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        req_r <= in_s;
                        if (LATENCY == 1) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= rsp_data_s;
                            resp_rd    <= rsp_rd_s;
                            resp_err   <= src_err_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rsp_data_s;
                        resp_rd    <= rsp_rd_s;
                        resp_err   <= src_err_s;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed load/store scenarios plus randomized
// traffic checked against a byte-level reference model of the memory.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int tests  = 0;
    int failed = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rdata;
    logic [4:0]  last_rd;
    logic        last_err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic ok;
        if (w) begin
            ok = (f3 == 3'd0) || (f3 == 3'd1 && a[0] == 1'b0) || (f3 == 3'd2 && a[1:0] == 2'd0);
        end else begin
            ok = (f3 == 3'd0) || (f3 == 3'd4) ||
                 ((f3 == 3'd1 || f3 == 3'd5) && a[0] == 1'b0) ||
                 (f3 == 3'd2 && a[1:0] == 2'd0);
        end
        return !ok;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = model_mem[widx(a)];
        b = (w >> (32'(a[1:0]) * 8)) & 32'hFF;
        h = (w >> (32'(a[1]) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size;
        int lane;
        logic [31:0] w;
        size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        w = model_mem[widx(a)];
        for (int k = 0; k < size; k++) begin
            lane = int'(a[1:0]) + k;
            w[lane*8 +: 8] = d[k*8 +: 8];
        end
        model_mem[widx(a)] = w;
    endtask

    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] rd, input string tag);
        logic        e_err;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        int cyc;
        int stalls;
        logic got;
        e_err  = model_err(w, f3, a);
        e_data = (e_err || w) ? 32'd0 : model_load(f3, a);
        e_rd   = (e_err || w) ? 5'd0 : rd;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3;
        req_addr = a; req_wdata = d; req_rd = rd;
        cyc = 0; stalls = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            #1;
            if (resp_valid) begin
                got = 1'b1;
            end else begin
                stalls += int'(stall);
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, ":latency"}, 32'(cyc), 32'(LAT));
        chk({tag, ":stall_cycles"}, 32'(stalls), 32'(LAT));
        chk({tag, ":stall_in_resp"}, 32'(stall), 32'd0);
        chk({tag, ":rdata"}, resp_rdata, e_data);
        chk({tag, ":rd"}, 32'(resp_rd), 32'(e_rd));
        chk({tag, ":err"}, 32'(resp_err), 32'(e_err));
        last_rdata = resp_rdata;
        last_rd    = resp_rd;
        last_err   = resp_err;
        req_valid  = 1'b0;
        if (got && !e_err && w) model_store(f3, a, d);
    endtask

    initial begin
        logic [31:0] r, hi, a;
        logic [7:0]  pat;
        int pulses;

        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        #12;
        chk("reset:stall", 32'(stall), 32'd0);
        chk("reset:resp_valid", 32'(resp_valid), 32'd0);
        chk("reset:rdata", resp_rdata, 32'd0);
        chk("reset:rd", 32'(resp_rd), 32'd0);
        chk("reset:err", 32'(resp_err), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd9, "sw10");
        op(1'b0, 3'd2, 32'h10, 32'd0, 5'd5, "lw10");
        chk("lw10:lit", last_rdata, 32'hDEADBEEF);
        chk("lw10:rd_lit", 32'(last_rd), 32'd5);
        op(1'b0, 3'd0, 32'h13, 32'd0, 5'd1, "lb13");
        chk("lb13:lit", last_rdata, 32'hFFFFFFDE);
        op(1'b0, 3'd4, 32'h13, 32'd0, 5'd2, "lbu13");
        chk("lbu13:lit", last_rdata, 32'h000000DE);
        op(1'b0, 3'd1, 32'h10, 32'd0, 5'd3, "lh10");
        chk("lh10:lit", last_rdata, 32'hFFFFBEEF);
        op(1'b0, 3'd5, 32'h12, 32'd0, 5'd4, "lhu12");
        chk("lhu12:lit", last_rdata, 32'h0000DEAD);
        op(1'b1, 3'd0, 32'h11, 32'h00000055, 5'd0, "sb11");
        op(1'b0, 3'd2, 32'h10, 32'd0, 5'd6, "lw10b");
        chk("lw10b:lit", last_rdata, 32'hDEAD55EF);
        op(1'b0, 3'd2, 32'h12, 32'd0, 5'd7, "lw12_mis");
        chk("lw12_mis:err_lit", 32'(last_err), 32'd1);
        op(1'b1, 3'd1, 32'h11, 32'h0000AAAA, 5'd0, "sh11_mis");
        op(1'b1, 3'd4, 32'h10, 32'h11111111, 5'd0, "st_f3_4");
        op(1'b0, 3'd3, 32'h10, 32'd0, 5'd8, "ld_f3_3");
        op(1'b0, 3'd2, 32'h10, 32'd0, 5'd6, "lw10c");
        chk("lw10c:lit", last_rdata, 32'hDEAD55EF);

        // reset while a store is waiting must drop it
        op(1'b1, 3'd2, 32'h20, 32'h12345678, 5'd0, "sw20");
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_rd = 5'd0;
        #1;
        chk("rstmid:stall_accept", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("rstmid:stall_wait", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid:stall", 32'(stall), 32'd0);
        chk("rstmid:resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid:stall_after", 32'(stall), 32'd0);
        op(1'b0, 3'd2, 32'h20, 32'd0, 5'd3, "lw20");
        chk("lw20:lit", last_rdata, 32'h12345678);

        // two loads with req_valid held high throughout
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h10; req_rd = 5'd1;
        pat = 8'd0; pulses = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            pat[c] = stall;
            pulses += int'(resp_valid);
            if (c == 5) req_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b:stall_pattern", 32'(pat), 32'h1B);
        chk("b2b:pulses", 32'(pulses), 32'd2);

        for (int k = 0; k < 16; k++) begin
            op(1'b1, 3'd2, 32'h100 + 32'(k) * 4, $urandom, 5'd0, "seed");
        end
        for (int i = 0; i < 60; i++) begin
            r  = $urandom;
            hi = $urandom;
            a  = {hi[31:12], 12'h000} + 32'h100 + 32'($urandom_range(0, 63));
            op(r[0], r[3:1], a, $urandom, r[8:4], "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
